// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sdffq_bank.sv
// Muxed-scan D flop bank with parallel load, serial shift and a saturating shift counter.
// Latency: 1 cycle load/shift; no backpressure. Options: GF180MCU_FD_SC_MCU7T5V0__SDFFQ_BANK_PARITY_EN, USE_POWER_PINS.
module gf180mcu_fd_sc_mcu7t5v0__sdffq_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
`ifdef USE_POWER_PINS
  inout  wire                          VDD,
  inout  wire                          VSS,
`endif
`ifdef GF180MCU_FD_SC_MCU7T5V0__SDFFQ_BANK_PARITY_EN
  output logic                         QPAR,
`endif
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [WIDTH-1:0]             D,
  input  logic                         E,
  input  logic                         SE,
  input  logic                         SI,
  output logic [WIDTH-1:0]             Q,
  output logic                         SO,
  output logic [$clog2(WIDTH+1)-1:0]   SCNT,
  output logic                         SDONE
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CMAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_nxt;

`ifdef USE_POWER_PINS
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;
`endif

  // Truncating {Q,SI} to WIDTH bits gives the left shift and also covers WIDTH=1.
  always_comb begin
    q_nxt = Q;
    if (SE) begin
      q_nxt = WIDTH'({Q, SI});
    end else if (E) begin
      q_nxt = D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= RESET_VAL;
    end else begin
      Q <= q_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SCNT <= '0;
    end else if (SE) begin
      if (SCNT != CMAX) begin
        SCNT <= SCNT + CW'(1);
      end
    end else begin
      SCNT <= '0;
    end
  end

`ifdef GF180MCU_FD_SC_MCU7T5V0__SDFFQ_BANK_PARITY_EN
  // Parity is taken from the next value so it tracks Q with no extra cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      QPAR <= ^RESET_VAL;
    end else begin
      QPAR <= ^q_nxt;
    end
  end
`endif

  assign SO    = Q[WIDTH-1];
  assign SDONE = (SCNT == CMAX);

endmodule
